// File: rtl/sound_pkg.sv
// Shared types and constants for the sample-memory read scheduler.
package sound_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUSIC = 2'd1,
      SFX   = 2'd2
   } sched_state_e;

   // Effect IDs double as priorities: a larger ID wins.
   localparam logic [1:0] SFX_NONE  = 2'd0;
   localparam logic [1:0] SFX_WHACK = 2'd1;
   localparam logic [1:0] SFX_MISS  = 2'd2;
   localparam logic [1:0] SFX_OVER  = 2'd3;

   localparam logic [22:0] DEF_MUSIC_START = 23'h00000;
   localparam logic [22:0] DEF_MUSIC_END   = 23'h4FFFF;
   localparam logic [22:0] DEF_WHACK_START = 23'h50000;
   localparam logic [22:0] DEF_WHACK_END   = 23'h51FFF;
   localparam logic [22:0] DEF_MISS_START  = 23'h52000;
   localparam logic [22:0] DEF_MISS_END    = 23'h53FFF;
   localparam logic [22:0] DEF_OVER_START  = 23'h54000;
   localparam logic [22:0] DEF_OVER_END    = 23'h57FFF;

   // Highest-priority effect among simultaneous request pulses.
   function automatic logic [1:0] req_id(input logic whack, input logic miss, input logic over);
      logic [1:0] id;
      id = SFX_NONE;
      if (over) begin
         id = SFX_OVER;
      end else if (miss) begin
         id = SFX_MISS;
      end else if (whack) begin
         id = SFX_WHACK;
      end
      return id;
   endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Delay line that lines up the memory read data (or a forced silent zero)
// with the sample_valid strobe toward the codec.
module mem_read_pipe #(
   parameter int MEM_LAT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       issue_i,
   input  logic       silent_i,
   input  logic [7:0] mem_data_i,
   output logic [7:0] sample_o,
   output logic       sample_valid_o
);

   logic [MEM_LAT-1:0] vld_q;
   logic [MEM_LAT-1:0] sil_q;
   logic [7:0]         sample_q;
   logic               sample_valid_q;

   // Shift the slot marker along while the memory works on the read.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         sil_q <= '0;
      end else begin
         vld_q[0] <= issue_i;
         sil_q[0] <= silent_i;
         for (int i = 1; i < MEM_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            sil_q[i] <= sil_q[i-1];
         end
      end
   end

   // Capture the read data (or zero for a silent slot) as the slot exits the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q       <= 8'h00;
         sample_valid_q <= 1'b0;
      end else begin
         sample_valid_q <= vld_q[MEM_LAT-1];
         if (vld_q[MEM_LAT-1]) begin
            sample_q <= sil_q[MEM_LAT-1] ? 8'h00 : mem_data_i;
         end
      end
   end

   assign sample_o       = sample_q;
   assign sample_valid_o = sample_valid_q;

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates the sample-memory read port between the looping background
// track and the whack / miss / game-over effects, one read per ready strobe.
//
//   state | meaning
//   IDLE  | nothing playing; each ready yields a silent sample
//   MUSIC | background track reading music_address, wrapping at the end
//   SFX   | effect playing; music_address frozen until it finishes
module sound_scheduler
   import sound_pkg::*;
#(
   parameter logic [22:0] MUSIC_START = DEF_MUSIC_START,
   parameter logic [22:0] MUSIC_END   = DEF_MUSIC_END,
   parameter logic [22:0] WHACK_START = DEF_WHACK_START,
   parameter logic [22:0] WHACK_END   = DEF_WHACK_END,
   parameter logic [22:0] MISS_START  = DEF_MISS_START,
   parameter logic [22:0] MISS_END    = DEF_MISS_END,
   parameter logic [22:0] OVER_START  = DEF_OVER_START,
   parameter logic [22:0] OVER_END    = DEF_OVER_END,
   parameter int          MEM_LAT     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready,
   input  logic        music_enable,
   input  logic        whack_req,
   input  logic        miss_req,
   input  logic        over_req,
   input  logic [7:0]  mem_data,
   output logic [22:0] mem_addr,
   output logic        mem_read,
   output logic [22:0] music_address,
   output logic        music_wrap,
   output logic [7:0]  sample_out,
   output logic        sample_valid,
   output logic [1:0]  sfx_active
);

   sched_state_e state_q;
   logic [1:0]   pending_q, pending_d;
   logic [22:0]  mem_addr_q;
   logic         mem_read_q;
   logic         slot_q;
   logic [22:0]  music_addr_q;
   logic         wrap_q;
   logic [1:0]   sfx_q;
   logic [22:0]  sfx_addr_q;
   logic [22:0]  sfx_end_q;
   logic         sfx_done_q;

   logic [22:0]  pend_start;
   logic [22:0]  pend_end;
   logic         take_sfx;
   logic         take_music;
   logic         step_sfx;
   logic         go_idle;
   logic [1:0]   new_id;
   logic [1:0]   pend_base;

   // Region of whichever effect is waiting in the pending slot.
   always_comb begin
      pend_start = MUSIC_START;
      pend_end   = MUSIC_END;
      case (pending_q)
         SFX_WHACK: begin
            pend_start = WHACK_START;
            pend_end   = WHACK_END;
         end
         SFX_MISS: begin
            pend_start = MISS_START;
            pend_end   = MISS_END;
         end
         SFX_OVER: begin
            pend_start = OVER_START;
            pend_end   = OVER_END;
         end
         default: ;
      endcase
   end

   // Decide what this ready does; every effect start consumes the pending slot.
   always_comb begin
      take_sfx   = 1'b0;
      take_music = 1'b0;
      step_sfx   = 1'b0;
      go_idle    = 1'b0;
      if (ready) begin
         case (state_q)
            IDLE: begin
               if (pending_q != SFX_NONE) begin
                  take_sfx = 1'b1;
               end else if (music_enable) begin
                  take_music = 1'b1;
               end
            end
            MUSIC: begin
               if (pending_q != SFX_NONE) begin
                  take_sfx = 1'b1;
               end else if (music_enable) begin
                  take_music = 1'b1;
               end else begin
                  go_idle = 1'b1;
               end
            end
            SFX: begin
               // Game over cuts any other effect short; everything else queues.
               if (pending_q == SFX_OVER && sfx_q != SFX_OVER) begin
                  take_sfx = 1'b1;
               end else if (sfx_done_q) begin
                  if (pending_q != SFX_NONE) begin
                     take_sfx = 1'b1;
                  end else if (music_enable) begin
                     take_music = 1'b1;
                  end else begin
                     go_idle = 1'b1;
                  end
               end else begin
                  step_sfx = 1'b1;
               end
            end
            default: go_idle = 1'b1;
         endcase
      end
   end

   // Pending slot: a new request replaces it only when at least as important.
   always_comb begin
      new_id    = req_id(whack_req, miss_req, over_req);
      pend_base = take_sfx ? SFX_NONE : pending_q;
      pending_d = pend_base;
      if (new_id != SFX_NONE && new_id >= pend_base) begin
         pending_d = new_id;
      end
   end

   // Register the pending request.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= SFX_NONE;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Scheduler FSM with registered read-port and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_addr_q   <= MUSIC_START;
         mem_read_q   <= 1'b0;
         slot_q       <= 1'b0;
         music_addr_q <= MUSIC_START;
         wrap_q       <= 1'b0;
         sfx_q        <= SFX_NONE;
         sfx_addr_q   <= MUSIC_START;
         sfx_end_q    <= MUSIC_START;
         sfx_done_q   <= 1'b0;
      end else begin
         mem_read_q <= 1'b0;
         wrap_q     <= 1'b0;
         slot_q     <= ready;
         if (take_sfx) begin
            state_q    <= SFX;
            mem_read_q <= 1'b1;
            mem_addr_q <= pend_start;
            sfx_addr_q <= pend_start + 23'd1;
            sfx_end_q  <= pend_end;
            sfx_done_q <= (pend_start == pend_end);
            sfx_q      <= pending_q;
         end else if (take_music) begin
            state_q    <= MUSIC;
            mem_read_q <= 1'b1;
            mem_addr_q <= music_addr_q;
            sfx_q      <= SFX_NONE;
            if (music_addr_q == MUSIC_END) begin
               music_addr_q <= MUSIC_START;
               wrap_q       <= 1'b1;
            end else begin
               music_addr_q <= music_addr_q + 23'd1;
            end
         end else if (step_sfx) begin
            mem_read_q <= 1'b1;
            mem_addr_q <= sfx_addr_q;
            sfx_addr_q <= sfx_addr_q + 23'd1;
            sfx_done_q <= (sfx_addr_q == sfx_end_q);
         end else if (go_idle) begin
            state_q      <= IDLE;
            sfx_q        <= SFX_NONE;
            music_addr_q <= MUSIC_START;
         end
      end
   end

   mem_read_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_pipe (
      .clk            (clk),
      .reset          (reset),
      .issue_i        (slot_q),
      .silent_i       (slot_q & ~mem_read_q),
      .mem_data_i     (mem_data),
      .sample_o       (sample_out),
      .sample_valid_o (sample_valid)
   );

   assign mem_addr      = mem_addr_q;
   assign mem_read      = mem_read_q;
   assign music_address = music_addr_q;
   assign music_wrap    = wrap_q;
   assign sfx_active    = sfx_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler with shortened address regions.
module tb_sound_scheduler;

   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ready = 1'b0;
   logic        music_enable = 1'b0;
   logic        whack_req = 1'b0;
   logic        miss_req = 1'b0;
   logic        over_req = 1'b0;
   logic [7:0]  mem_data;
   logic [22:0] mem_addr;
   logic        mem_read;
   logic [22:0] music_address;
   logic        music_wrap;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic [1:0]  sfx_active;

   typedef struct packed {
      logic [22:0] addr;
      logic [1:0]  sfx;
      logic        wrap;
   } rd_exp_t;

   rd_exp_t    rd_q[$];
   logic [7:0] smp_q[$];
   int         cyc_q[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [22:0] a1 = '0;
   logic [22:0] a2 = '0;

   sound_scheduler #(
      .MUSIC_START (23'h00000),
      .MUSIC_END   (23'h0000F),
      .WHACK_START (23'h50000),
      .WHACK_END   (23'h5001F),
      .MISS_START  (23'h52000),
      .MISS_END    (23'h5200F),
      .OVER_START  (23'h54000),
      .OVER_END    (23'h5400F),
      .MEM_LAT     (MEM_LAT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ready         (ready),
      .music_enable  (music_enable),
      .whack_req     (whack_req),
      .miss_req      (miss_req),
      .over_req      (over_req),
      .mem_data      (mem_data),
      .mem_addr      (mem_addr),
      .mem_read      (mem_read),
      .music_address (music_address),
      .music_wrap    (music_wrap),
      .sample_out    (sample_out),
      .sample_valid  (sample_valid),
      .sfx_active    (sfx_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_fn(input logic [22:0] a);
      return a[7:0] ^ 8'hA5 ^ {4'h0, a[19:16]};
   endfunction

   // Two-cycle memory model.
   always @(posedge clk) begin
      a1 <= mem_addr;
      a2 <= a1;
   end
   assign mem_data = mem_fn(a2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      rd_exp_t e;
      logic [7:0] s;
      int r;
      if (mem_read) begin
         if (rd_q.size() == 0) begin
            chk("unexpected_read", {9'd0, mem_addr}, 32'hFFFFFFFF);
         end else begin
            e = rd_q.pop_front();
            chk("mem_addr", {9'd0, mem_addr}, {9'd0, e.addr});
            chk("sfx_active", {30'd0, sfx_active}, {30'd0, e.sfx});
            chk("music_wrap", {31'd0, music_wrap}, {31'd0, e.wrap});
         end
      end else if (music_wrap) begin
         chk("stray_wrap", 32'd1, 32'd0);
      end
      if (sample_valid) begin
         if (smp_q.size() == 0) begin
            chk("unexpected_sample", {24'd0, sample_out}, 32'hFFFFFFFF);
         end else begin
            s = smp_q.pop_front();
            r = cyc_q.pop_front();
            chk("sample_out", {24'd0, sample_out}, {24'd0, s});
            chk("sample_latency", cyc - r, MEM_LAT + 2);
         end
      end
   end

   task automatic pulse_ready(input bit rd, input logic [22:0] addr, input logic [1:0] sfx,
                              input bit wrap);
      rd_exp_t e;
      if (rd) begin
         e.addr = addr;
         e.sfx  = sfx;
         e.wrap = wrap;
         rd_q.push_back(e);
      end
      smp_q.push_back(rd ? mem_fn(addr) : 8'h00);
      cyc_q.push_back(cyc);
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic req(input bit w, input bit m, input bit o);
      whack_req = w;
      miss_req  = m;
      over_req  = o;
      @(posedge clk); #1;
      whack_req = 1'b0;
      miss_req  = 1'b0;
      over_req  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rd_exp_t e;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_music_address", {9'd0, music_address}, 32'd0);
      chk("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_sample_out", {24'd0, sample_out}, 32'd0);
      chk("rst_sfx_active", {30'd0, sfx_active}, 32'd0);

      // Plain music from the start of the track.
      music_enable = 1'b1;
      for (int i = 0; i < 4; i++) pulse_ready(1, 23'(i), 2'd0, 0);
      chk("music_addr_after4", {9'd0, music_address}, 32'd4);

      // Run through the end of the track and wrap.
      for (int i = 4; i <= 16; i++) pulse_ready(1, 23'(i % 16), 2'd0, i == 15);
      chk("music_addr_after_wrap", {9'd0, music_address}, 32'd1);

      // Whack during music; music resumes where it stopped.
      for (int i = 1; i <= 4; i++) pulse_ready(1, 23'(i), 2'd0, 0);
      req(1, 0, 0);
      for (int a = 0; a < 32; a++) pulse_ready(1, 23'h50000 + 23'(a), 2'd1, 0);
      chk("music_held_in_sfx", {9'd0, music_address}, 32'd5);
      pulse_ready(1, 23'd5, 2'd0, 0);
      chk("music_addr_resume", {9'd0, music_address}, 32'd6);

      // Whack and miss together: miss plays, whack is dropped.
      req(1, 1, 0);
      for (int a = 0; a < 16; a++) pulse_ready(1, 23'h52000 + 23'(a), 2'd2, 0);
      pulse_ready(1, 23'd6, 2'd0, 0);
      pulse_ready(1, 23'd7, 2'd0, 0);

      // Game over preempts a whack; with music off it ends in IDLE.
      req(1, 0, 0);
      for (int a = 0; a <= 16; a++) pulse_ready(1, 23'h50000 + 23'(a), 2'd1, 0);
      req(0, 0, 1);
      music_enable = 1'b0;
      for (int a = 0; a < 16; a++) pulse_ready(1, 23'h54000 + 23'(a), 2'd3, 0);
      pulse_ready(0, 23'd0, 2'd0, 0);
      chk("idle_sfx_active", {30'd0, sfx_active}, 32'd0);
      chk("idle_music_address", {9'd0, music_address}, 32'd0);
      pulse_ready(0, 23'd0, 2'd0, 0);

      // Miss queued behind a whack starts straight after it.
      music_enable = 1'b1;
      pulse_ready(1, 23'd0, 2'd0, 0);
      req(1, 0, 0);
      pulse_ready(1, 23'h50000, 2'd1, 0);
      pulse_ready(1, 23'h50001, 2'd1, 0);
      req(0, 1, 0);
      for (int a = 2; a < 32; a++) pulse_ready(1, 23'h50000 + 23'(a), 2'd1, 0);
      for (int a = 0; a < 16; a++) pulse_ready(1, 23'h52000 + 23'(a), 2'd2, 0);
      pulse_ready(1, 23'd1, 2'd0, 0);
      chk("music_after_queued", {9'd0, music_address}, 32'd2);

      // Reset one cycle after a read: the in-flight sample must vanish.
      req(1, 0, 0);
      e.addr = 23'h50000;
      e.sfx  = 2'd1;
      e.wrap = 1'b0;
      rd_q.push_back(e);
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_mem_addr", {9'd0, mem_addr}, 32'd0);
      chk("mid_rst_sfx_active", {30'd0, sfx_active}, 32'd0);
      chk("mid_rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("mid_rst_music_address", {9'd0, music_address}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("rd_queue_empty", rd_q.size(), 32'd0);
      chk("sample_queue_empty", smp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Sequences the single sample-memory read port between the looping background track and three event sound effects (whack, miss, game over). Sits between the game-state FSM, which produces the event pulses, and the audio codec path, which consumes one sample per `ready` strobe. It also drives `music_address`, which the mole-timing logic compares against its pop-up table, so mole scheduling freezes while an effect plays.

## Interface
Parameters:
- `MUSIC_START`, default 23'h00000: first address of the background track.
- `MUSIC_END`, default 23'h4FFFF: last address of the background track (inclusive).
- `WHACK_START`, default 23'h50000; `WHACK_END`, default 23'h51FFF: whack effect region.
- `MISS_START`, default 23'h52000; `MISS_END`, default 23'h53FFF: miss effect region.
- `OVER_START`, default 23'h54000; `OVER_END`, default 23'h57FFF: game-over effect region.
- `MEM_LAT`, default 2: sample-memory read latency in cycles, counted from `mem_read` to valid `mem_data`.

Ports:
- `clk` in 1: system clock (27 MHz).
- `reset` in 1: one clock; reset is synchronous and active-high.
- `ready` in 1: one-cycle sample strobe from the codec. Strobes are at least MEM_LAT+2 cycles apart.
- `music_enable` in 1: level; background track plays while high.
- `whack_req`, `miss_req`, `over_req` in 1 each: one-cycle effect requests.
- `mem_data` in 8: read data from sample memory.
- `mem_addr` out 23: read address.
- `mem_read` out 1: one-cycle read strobe.
- `music_address` out 23: current background position.
- `music_wrap` out 1: one-cycle pulse when the track wraps.
- `sample_out` out 8: sample to the codec.
- `sample_valid` out 1: one-cycle pulse when `sample_out` updates.
- `sfx_active` out 2: effect currently playing. Encoding: 0 none, 1 whack, 2 miss, 3 over.

## Operation
- Reset values: `mem_addr`=MUSIC_START, `mem_read`=0, `music_address`=MUSIC_START, `music_wrap`=0, `sample_out`=0, `sample_valid`=0, `sfx_active`=0, pending=0, state=IDLE.
- States: IDLE, MUSIC, SFX. State changes happen only on cycles where `ready` is high.
- Pending slot (2-bit ID): holds one request, evaluated every cycle.
  - Request IDs are numeric priorities: over=3 > miss=2 > whack=1.
  - If several requests arrive in the same cycle, the highest ID wins.
  - A new request overwrites pending only if its ID ≥ pending. Lower requests are dropped.
- Transitions and reads, all on `ready`:
  - IDLE: if pending≠0, go to SFX. Otherwise, if `music_enable` is high, go to MUSIC and issue the read for the first sample. Otherwise stay in IDLE.
  - IDLE with no read issued: still emit `sample_valid` with `sample_out`=0 at the normal latency.
  - MUSIC: if pending≠0, go to SFX and clear pending. `music_address` is held; that `ready` reads the first effect sample.
  - MUSIC with `music_enable` low: go to IDLE and set `music_address`=MUSIC_START; this `ready` emits a silent sample.
  - MUSIC otherwise: read `music_address`, then increment it. At MUSIC_END, wrap to MUSIC_START and pulse `music_wrap`.
  - SFX: read the effect address and increment it.
  - After reading the effect's END address: load pending if it is nonzero. Otherwise go to MUSIC if `music_enable` is high, else go to IDLE and reset `music_address` to MUSIC_START.
  - Preemption: in SFX, if pending=3 and `sfx_active`≠3, switch immediately to OVER_START on that `ready`. All other requests wait for the current effect to finish.
- `sfx_active` is updated on the `ready` that issues the effect's first read. It returns to 0 on the `ready` that leaves SFX.
- Address arithmetic is 23-bit unsigned; no overflow is possible within the declared regions.

## Timing
- A `ready` at cycle N produces `mem_read`=1 and a valid `mem_addr` at cycle N+1.
- Memory data is captured at N+1+MEM_LAT. `sample_out` and `sample_valid` update at N+2+MEM_LAT.
- A request pulse at cycle N is visible in pending at N+1. A request coinciding with `ready` therefore takes effect at the following `ready`.
- `music_wrap` pulses at N+1 alongside the MUSIC_END read.
- Reset mid-operation: all outputs return to their reset values on the next edge, and any in-flight sample is discarded (no `sample_valid`).

## Structure
- Shared package `sound_pkg`:
  - state enum (IDLE, MUSIC, SFX);
  - sfx ID constants (SFX_NONE, SFX_WHACK, SFX_MISS, SFX_OVER);
  - the default address-map constants.
- Sub-module `mem_read_pipe`: MEM_LAT-deep valid/silence delay line that aligns the captured `mem_data` or the forced zero with `sample_valid`.

## Test plan
- Reset, `music_enable`=1, 4 `ready` strobes → `mem_addr` 0,1,2,3; `music_address` ends at 4; each `sample_valid` arrives at N+4 (MEM_LAT=2).
- `music_address` forced near MUSIC_END (23'h4FFFE), 3 `ready` strobes → reads 4FFFE, 4FFFF, 00000; `music_wrap` pulses once.
- `whack_req` during music at `music_address`=100 → next `ready` reads 23'h50000 with `sfx_active`=1; after 23'h51FFF is read, music resumes at address 100.
- `whack_req` and `miss_req` in the same cycle → miss plays; whack is dropped; `sfx_active`=2.
- `over_req` during a whack at 23'h50010 → next `ready` reads 23'h54000 with `sfx_active`=3; with `music_enable` low, reaches IDLE after 23'h57FFF.
- `reset` asserted 1 cycle after a `mem_read` → no `sample_valid` follows; `mem_addr`=0 and `sfx_active`=0.
